wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the 8-register, 16-bit MIPS-style datapath. It sits directly downstream of the 3-bit destination-register select mux. The WB pipeline latch captures the selected destination (rd, rt, link R7 or R1) with its result data, and the write into the register file happens one cycle later. Two combinational read ports with write-back bypass serve decode, and a retired-write counter supports debug and performance checks.

## Interface
- DATA_W, 16, register and data width
- NREG, 8, number of registers; fixed by the 3-bit destination address

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid_in  in  1  MEM stage holds a valid instruction
- wb_reg_write_in  in  1  instruction writes a register
- wb_dest_in  in  3  destination register from the destination select mux
- wb_data_in  in  DATA_W  result to write
- stall  in  1  pipeline stall; WB latch loads a bubble
- flush  in  1  squash; WB latch loads a bubble
- rs_addr  in  3  read port A address
- rt_addr  in  3  read port B address
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- wb_we_q  out  1  latched write enable (valid & reg_write); feeds the hazard unit
- wb_dest_q  out  3  latched destination
- wb_data_q  out  DATA_W  latched result
- retire_cnt  out  16  count of committed register writes

## Operation
- WB latch update, every rising edge:
  - If stall or flush is high, the latch loads a bubble: wb_we_q=0. Dest and data hold their old values and are don't-care.
  - Otherwise the latch loads wb_we_q = wb_valid_in & wb_reg_write_in, and loads wb_dest_in and wb_data_in.
- Commit, every rising edge:
  - If wb_we_q=1 and wb_dest_q!=0, then reg[wb_dest_q] <= wb_data_q and retire_cnt increments.
  - A write to R0 is discarded and is not counted.
- R0 reads as 0 at all times. R1–R7 are ordinary storage. R7 is the link register by convention only; no special hardware.
- Read ports are combinational:
  - If the address is 0, the port returns 0.
  - Else if wb_we_q=1 and wb_dest_q equals the address, the port returns wb_data_q (bypass of the write committing at the next edge).
  - Else the port returns reg[addr].
- Both ports may read the same register, and either may hit the bypass.
- Commit and latch capture on the same edge are independent. The latch may load a new instruction while the old one commits.
- retire_cnt wraps from 0xFFFF to 0x0000.

## Timing
- Reset (rst_n=0, asynchronous):
  - All registers = 0, wb_we_q=0, wb_dest_q=0, wb_data_q=0, retire_cnt=0.
  - rs_data and rt_data = 0 for any address.
  - An in-flight latched write is lost and is not committed.
- Reset release is synchronous to the clk domain. The first capture happens on the first rising edge with rst_n=1.
- Latency from input to architectural state:
  - An input sampled at edge N is visible on the read ports via bypass during cycle N..N+1.
  - It is committed to storage at edge N+1.
  - Storage reads return it from cycle N+1 onward.
- Stall and flush asserted together produce a bubble; there is no priority issue. A bubble never commits and never bypasses.
- Back-to-back writes to the same register: the younger one is in the latch, so the bypass returns the younger value. After both commit, storage holds the younger value.
- Input X/garbage on wb_dest_in or wb_data_in when wb_valid_in=0 must have no architectural effect.

## Test plan
- Reset: with rst_n=0, read all addresses -> every read returns 0x0000; wb_we_q=0; retire_cnt=0.
- Basic write: edge 1 drive valid=1, reg_write=1, dest=3, data=0xBEEF; rs_addr=3 -> rs_data=0xBEEF during the cycle after edge 1 (bypass) and after edge 2 (storage); retire_cnt=1.
- R0 and link: write 0x1234 to dest=0, then 0x0042 to dest=7 -> reading R0 returns 0; reading R7 returns 0x0042; retire_cnt increases by 1, not 2.
- Stall/flush: present a write of 0x5555 to R2 with stall=1, then again with flush=1 -> R2 stays 0; wb_we_q=0; retire_cnt unchanged.
- Back-to-back same register: write 0x1111 then 0x2222 to R5 on consecutive edges, with rs_addr=rt_addr=5 -> both ports read 0x1111 then 0x2222 via bypass; R5 ends at 0x2222.
- Reset mid-operation and wrap: assert rst_n low while wb_we_q=1 for R4=0xAAAA -> R4 remains 0. Separately, preload retire_cnt to 0xFFFF by issuing 65535 writes, then one more write -> retire_cnt reads 0x0000.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bus bundle for the write-back latch and register-file read ports of wb_regfile.
interface wb_regfile_if #(
  parameter int DATA_W = 16
);
  logic              wb_valid_in;
  logic              wb_reg_write_in;
  logic [2:0]        wb_dest_in;
  logic [DATA_W-1:0] wb_data_in;
  logic              stall;
  logic              flush;
  logic [2:0]        rs_addr;
  logic [2:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wb_we_q;
  logic [2:0]        wb_dest_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [15:0]       retire_cnt;

  modport master (
    output wb_valid_in, wb_reg_write_in, wb_dest_in, wb_data_in,
    output stall, flush, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_we_q, wb_dest_q, wb_data_q, retire_cnt
  );

  modport slave (
    input  wb_valid_in, wb_reg_write_in, wb_dest_in, wb_data_in,
    input  stall, flush, rs_addr, rt_addr,
    output rs_data, rt_data, wb_we_q, wb_dest_q, wb_data_q, retire_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back pipeline latch plus 8x16 register file with bypassed read ports
// and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);
  logic              we_q;
  logic [2:0]        dest_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       cnt_q;
  logic [DATA_W-1:0] regs [NREG];
  logic              commit;

  assign commit = we_q && (dest_q != 3'd0);

  // Bubbles clear only the enable; dest/data hold since they are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else if (bus.stall || bus.flush) begin
      we_q <= 1'b0;
    end else begin
      we_q   <= bus.wb_valid_in && bus.wb_reg_write_in;
      dest_q <= bus.wb_dest_in;
      data_q <= bus.wb_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      cnt_q <= '0;
    end else if (commit) begin
      regs[dest_q] <= data_q;
      cnt_q        <= cnt_q + 16'd1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [2:0] addr);
    if (addr == 3'd0)
      return '0;
    else if (we_q && (dest_q == addr))
      return data_q;
    else
      return regs[addr];
  endfunction

  always_comb begin
    bus.rs_data = read_port(bus.rs_addr);
    bus.rt_data = read_port(bus.rt_addr);
  end

  assign bus.wb_we_q    = we_q;
  assign bus.wb_dest_q  = dest_q;
  assign bus.wb_data_q  = data_q;
  assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an array-based architectural model.
module tb_wb_regfile;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wb_regfile_if #(.DATA_W(16)) bus ();

  wb_regfile #(.DATA_W(16), .NREG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: register array, one pending write, commit counter.
  logic [15:0] m_reg [8];
  logic        m_we;
  logic [2:0]  m_dest;
  logic [15:0] m_data;
  logic [15:0] m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_we   = 1'b0;
    m_dest = 3'd0;
    m_data = 16'h0000;
    m_cnt  = 16'h0000;
  endfunction

  function automatic void model_edge();
    if (m_we && m_dest != 3'd0) begin
      m_reg[m_dest] = m_data;
      m_cnt = m_cnt + 16'd1;
    end
    if (bus.stall || bus.flush) begin
      m_we = 1'b0;
    end else begin
      m_we   = bus.wb_valid_in & bus.wb_reg_write_in;
      m_dest = bus.wb_dest_in;
      m_data = bus.wb_data_in;
    end
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (m_we && m_dest == a) return m_data;
    return m_reg[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic [15:0] x);
    bus.wb_valid_in     = v;
    bus.wb_reg_write_in = v;
    bus.wb_dest_in      = d;
    bus.wb_data_in      = x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, 3'd0, 16'h0000);
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.rs_addr = 3'd0; bus.rt_addr = 3'd0;
    #12;
    for (int a = 0; a < 8; a++) begin
      bus.rs_addr = 3'(a);
      bus.rt_addr = 3'(7 - a);
      #1;
      checks++;
      if (bus.rs_data !== 16'h0000 || bus.rt_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read addr=%0d got rs=%h rt=%h expected 0000", a, bus.rs_data, bus.rt_data);
      end
    end
    checks++;
    if (bus.wb_we_q !== 1'b0 || bus.retire_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got we=%b cnt=%h expected we=0 cnt=0000", bus.wb_we_q, bus.retire_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 3'd3, 16'hBEEF);
    bus.rs_addr = 3'd3;
    tick();
    drive(1'b0, 3'd0, 16'h0000);
    checks++;
    if (bus.rs_data !== 16'hBEEF || bus.wb_we_q !== 1'b1) begin
      errors++;
      $display("FAIL basic_bypass got rs=%h we=%b expected BEEF we=1", bus.rs_data, bus.wb_we_q);
    end
    tick();
    checks++;
    if (bus.rs_data !== 16'hBEEF || bus.retire_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_commit got rs=%h cnt=%h expected BEEF cnt=0001", bus.rs_data, bus.retire_cnt);
    end
  endtask

  task automatic test_r0_link();
    logic [15:0] c0;
    c0 = m_cnt;
    bus.rs_addr = 3'd0;
    bus.rt_addr = 3'd7;
    drive(1'b1, 3'd0, 16'h1234);
    tick();
    checks++;
    if (bus.rs_data !== 16'h0000) begin
      errors++;
      $display("FAIL r0_bypass got %h expected 0000", bus.rs_data);
    end
    drive(1'b1, 3'd7, 16'h0042);
    tick();
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    checks++;
    if (bus.rs_data !== 16'h0000 || bus.rt_data !== 16'h0042 || bus.retire_cnt !== c0 + 16'd1) begin
      errors++;
      $display("FAIL r0_link got r0=%h r7=%h cnt=%h expected 0000 0042 %h",
               bus.rs_data, bus.rt_data, bus.retire_cnt, c0 + 16'd1);
    end
  endtask

  task automatic test_stall_flush();
    logic [15:0] c0;
    c0 = m_cnt;
    bus.rs_addr = 3'd2;
    drive(1'b1, 3'd2, 16'h5555);
    bus.stall = 1'b1;
    tick();
    checks++;
    if (bus.wb_we_q !== 1'b0 || bus.rs_data !== 16'h0000) begin
      errors++;
      $display("FAIL stall_bubble got we=%b rs=%h expected we=0 rs=0000", bus.wb_we_q, bus.rs_data);
    end
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    tick();
    checks++;
    if (bus.wb_we_q !== 1'b0 || bus.rs_data !== 16'h0000) begin
      errors++;
      $display("FAIL flush_bubble got we=%b rs=%h expected we=0 rs=0000", bus.wb_we_q, bus.rs_data);
    end
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    checks++;
    if (bus.rs_data !== 16'h0000 || bus.retire_cnt !== c0) begin
      errors++;
      $display("FAIL stall_flush_state got r2=%h cnt=%h expected 0000 %h", bus.rs_data, bus.retire_cnt, c0);
    end
  endtask

  task automatic test_back_to_back();
    bus.rs_addr = 3'd5;
    bus.rt_addr = 3'd5;
    drive(1'b1, 3'd5, 16'h1111);
    tick();
    checks++;
    if (bus.rs_data !== 16'h1111 || bus.rt_data !== 16'h1111) begin
      errors++;
      $display("FAIL b2b_first got rs=%h rt=%h expected 1111", bus.rs_data, bus.rt_data);
    end
    drive(1'b1, 3'd5, 16'h2222);
    tick();
    checks++;
    if (bus.rs_data !== 16'h2222 || bus.rt_data !== 16'h2222) begin
      errors++;
      $display("FAIL b2b_second got rs=%h rt=%h expected 2222", bus.rs_data, bus.rt_data);
    end
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    tick();
    checks++;
    if (bus.rs_data !== 16'h2222 || bus.rt_data !== 16'h2222) begin
      errors++;
      $display("FAIL b2b_final got rs=%h rt=%h expected 2222", bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.wb_valid_in     = ($urandom_range(0, 9) < 7);
      bus.wb_reg_write_in = ($urandom_range(0, 9) < 8);
      bus.wb_dest_in      = 3'($urandom_range(0, 7));
      bus.wb_data_in      = 16'($urandom);
      bus.stall           = ($urandom_range(0, 9) == 0);
      bus.flush           = ($urandom_range(0, 9) == 0);
      bus.rs_addr         = 3'($urandom_range(0, 7));
      bus.rt_addr         = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if (bus.rs_data !== exp_read(bus.rs_addr) || bus.rt_data !== exp_read(bus.rt_addr)) begin
        errors++;
        $display("FAIL rand_read n=%0d got rs=%h rt=%h expected %h %h",
                 n, bus.rs_data, bus.rt_data, exp_read(bus.rs_addr), exp_read(bus.rt_addr));
      end
      checks++;
      if (bus.wb_we_q !== m_we || bus.retire_cnt !== m_cnt ||
          (m_we && (bus.wb_dest_q !== m_dest || bus.wb_data_q !== m_data))) begin
        errors++;
        $display("FAIL rand_latch n=%0d got we=%b dest=%0d data=%h cnt=%h expected %b %0d %h %h",
                 n, bus.wb_we_q, bus.wb_dest_q, bus.wb_data_q, bus.retire_cnt,
                 m_we, m_dest, m_data, m_cnt);
      end
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0000);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.rs_addr = 3'd4;
    drive(1'b1, 3'd4, 16'hAAAA);
    tick();
    drive(1'b0, 3'd0, 16'h0000);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.wb_we_q !== 1'b0 || bus.rs_data !== 16'h0000 || bus.retire_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid got we=%b r4=%h cnt=%h expected 0 0000 0000",
               bus.wb_we_q, bus.rs_data, bus.retire_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.rs_data !== 16'h0000 || bus.retire_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_after got r4=%h cnt=%h expected 0000 0000", bus.rs_data, bus.retire_cnt);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 3'd1, 16'h0F0F);
    repeat (65535) tick();
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    checks++;
    if (bus.retire_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload got %h expected FFFF", bus.retire_cnt);
    end
    drive(1'b1, 3'd6, 16'h7777);
    tick();
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    checks++;
    if (bus.retire_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_rollover got %h expected 0000", bus.retire_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_r0_link();
    test_stall_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
